// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: start/load/stage-stepping control sequencer for the 32-point radix-2 FFT core
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   rst_n           asynchronous active-low reset
//   i_start         transform request, honoured only while idle
//   i_in_valid      one input sample written to the banks this cycle
//   o_in_ready      sequencer is accepting samples
//   o_ld_data       bank contents valid, to stage control
//   o_en            stage enable, to stage control
//   o_stage_num     current stage index, to stage control
//   i_stage_done    current stage finished, from stage control
//   o_busy          transform in progress
//   o_fft_done      one-cycle completion pulse
//   o_timeout_err   sticky stalled-stage flag, cleared by the next accepted start
module fft_stage_sequencer #(
    parameter int NUMSTAGES  = 5,
    parameter int NUMSAMPLES = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic       o_ld_data,
    output logic       o_en,
    output logic [2:0] o_stage_num,
    input  logic       i_stage_done,
    output logic       o_busy,
    output logic       o_fft_done,
    output logic       o_timeout_err
);
    localparam int CW = $clog2(NUMSAMPLES + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [2:0]    LAST_STAGE = 3'(NUMSTAGES - 1);
    localparam logic [CW-1:0] LAST_SMPL  = CW'(NUMSAMPLES - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE, S_ERR} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [TW-1:0] r_timer, w_timer;
    logic [2:0]    r_stage, w_stage;
    logic          r_in_ready, w_in_ready;
    logic          r_ld_data, w_ld_data;
    logic          r_en, w_en;
    logic          r_busy, w_busy;
    logic          r_fft_done, w_fft_done;
    logic          r_terr, w_terr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_stage    <= '0;
            r_in_ready <= 1'b0;
            r_ld_data  <= 1'b0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_fft_done <= 1'b0;
            r_terr     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_timer    <= w_timer;
            r_stage    <= w_stage;
            r_in_ready <= w_in_ready;
            r_ld_data  <= w_ld_data;
            r_en       <= w_en;
            r_busy     <= w_busy;
            r_fft_done <= w_fft_done;
            r_terr     <= w_terr;
        end
    end

    // Every output is computed here as the value it takes after the next edge.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_timer    = r_timer;
        w_stage    = r_stage;
        w_in_ready = r_in_ready;
        w_ld_data  = r_ld_data;
        w_en       = r_en;
        w_busy     = r_busy;
        w_fft_done = r_fft_done;
        w_terr     = r_terr;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_state    = S_LOAD;
                w_cnt      = '0;
                w_terr     = 1'b0;
                w_busy     = 1'b1;
                w_in_ready = 1'b1;
            end
            S_LOAD: if (i_in_valid && r_in_ready) begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST_SMPL) begin
                    w_state    = S_RUN;
                    w_in_ready = 1'b0;
                    w_ld_data  = 1'b1;
                    w_en       = 1'b1;
                    w_stage    = '0;
                    w_timer    = '0;
                end
            end
            S_RUN: begin
                w_timer = r_timer + 1'b1;
                // stage_done takes priority over a timeout on the same cycle
                if (i_stage_done) begin
                    w_en       = 1'b0;
                    w_state    = (r_stage == LAST_STAGE) ? S_DONE : S_GAP;
                    w_fft_done = (r_stage == LAST_STAGE);
                    w_stage    = (r_stage == LAST_STAGE) ? r_stage : r_stage + 1'b1;
                end else if (r_timer == LAST_TICK) begin
                    w_state = S_ERR;
                    w_en    = 1'b0;
                    w_terr  = 1'b1;
                end
            end
            S_GAP: begin
                w_state = S_RUN;
                w_en    = 1'b1;
                w_timer = '0;
            end
            S_DONE, S_ERR: begin
                w_state    = S_IDLE;
                w_fft_done = 1'b0;
                w_ld_data  = 1'b0;
                w_busy     = 1'b0;
                w_stage    = '0;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign o_in_ready    = r_in_ready;
    assign o_ld_data     = r_ld_data;
    assign o_en          = r_en;
    assign o_stage_num   = r_stage;
    assign o_busy        = r_busy;
    assign o_fft_done    = r_fft_done;
    assign o_timeout_err = r_terr;
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Top-level control sequencer for the 32-point radix-2 FFT core. It drives the stage-control block that generates mux selects and bank addresses. It accepts a start request and counts the input sample load into the ping-pong banks. It then steps the stage controller through stages 0..NUMSTAGES-1 using the en/stage_num/stage_done handshake, and reports completion or a stalled stage.

## Interface
- NUMSTAGES, 5, number of butterfly stages (log2 NUMSAMPLES)
- NUMSAMPLES, 32, samples accepted during load
- TIMEOUT, 64, max cycles a stage may run before stage_done (≥ 2)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a transform; sampled only in IDLE
- in_valid  in  1  one input sample written to the banks this cycle
- in_ready  out  1  sequencer is accepting samples (LOAD state)
- ld_data  out  1  bank contents valid; to stage control
- en  out  1  stage enable; to stage control
- stage_num  out  3  current stage index; to stage control
- stage_done  in  1  current stage finished; from stage control
- busy  out  1  transform in progress (any state but IDLE)
- fft_done  out  1  one-cycle pulse, transform complete
- timeout_err  out  1  sticky: a stage exceeded TIMEOUT cycles

## Operation
- States: IDLE, LOAD, RUN, GAP, DONE, ERR. All outputs registered.
- Reset (async, rst_n=0): state IDLE. in_ready=0, ld_data=0, en=0, stage_num=0, busy=0, fft_done=0, timeout_err=0. Sample counter and stage timer are 0.
- IDLE: start=1 → LOAD. Clear sample counter and timeout_err. Set busy=1 and in_ready=1.
- LOAD: each cycle with in_valid&in_ready increments the sample counter (width clog2(NUMSAMPLES+1)). The NUMSAMPLES-th accepted sample → RUN, with in_ready=0, ld_data=1, en=1, stage_num=0 and the timer cleared. in_valid while in_ready=0 is ignored.
- RUN: the timer increments each cycle.
  - stage_done=1 with stage_num<NUMSTAGES-1 → GAP, with en=0 and stage_num+1.
  - stage_done=1 with stage_num=NUMSTAGES-1 → DONE, with en=0 and fft_done=1. stage_num holds.
  - Timer reaching TIMEOUT-1 without stage_done → ERR, with en=0 and timeout_err=1.
  - stage_done and timeout in the same cycle: stage_done wins.
- GAP: lasts exactly one cycle with en=0. Then → RUN with en=1 and the timer cleared. This en low cycle lets the stage controller re-arm its address counters.
- DONE: lasts one cycle. Then → IDLE with fft_done=0, ld_data=0, busy=0, stage_num=0.
- ERR: lasts one cycle. Then → IDLE with ld_data=0, busy=0, stage_num=0. timeout_err stays 1 until the next accepted start.
- stage_done outside RUN is ignored. start outside IDLE is ignored; there is no restart mid-transform.
- rst_n low in any state returns to the reset values immediately, independent of clk.

## Timing
- start→in_ready: 1 cycle.
- Last sample accepted at edge N → en=1, stage_num=0 visible after edge N.
- stage_done sampled at edge K → en=0 after K, en=1 with the new stage_num after K+1.
- Minimum transform time: 1 + NUMSAMPLES + NUMSTAGES·(stage length) + (NUMSTAGES-1) GAP cycles + 1 DONE cycle.
- fft_done is high exactly one cycle, coincident with en=0 and stage_num=NUMSTAGES-1. busy drops the cycle after.
- stage_num changes only on the RUN→GAP edge or on return to IDLE. It never exceeds NUMSTAGES-1.

## Test plan
- Reset mid-RUN (stage_num=2, en=1): drive rst_n=0 → all outputs 0 asynchronously. After release, a start runs a full clean transform.
- Nominal run: start, 32 consecutive in_valid, stage model returns stage_done 8 cycles after en rises. Required:
  - stage_num sequence 0,1,2,3,4
  - en low exactly one cycle between stages
  - one fft_done pulse
  - busy low the following cycle
- Gapped load: in_valid on alternate cycles. Required: in_ready stays high for 63 cycles, and RUN is entered only after the 32nd sample.
- Timeout: stage model never asserts stage_done in stage 3. Required: en drops TIMEOUT cycles after stage 3 starts, timeout_err=1, busy=0. The next start clears timeout_err.
- Ignored events: start pulses during LOAD/RUN, and stage_done pulses in IDLE/GAP. Required: no state change, no extra stage increments, fft_done count = 1 per transform.
